hilbert_mac_scheduler: RTL and testbench
========================================

# hilbert_mac_scheduler

Time-multiplexed controller for the Hilbert transformer datapath: on each sample tick it runs both FIR paths, the Hilbert (cos) path and the matched delay-line (sin) path, through one shared multiplier-accumulator instead of two parallel FIR filters. It stores the last COEFF_LENGTH samples, schedules 2·COEFF_LENGTH multiply-accumulate cycles, then saturates and presents the sin/cos pair with a one-cycle done pulse. It sits between the sample source (ADC/decimator tick domain) and the downstream phase/demodulation logic, as a drop-in for the parallel Hilbert transformer where DSP slices are scarce.

## Interface
- NUM_BITS, 24, sample/coefficient width, signed Q1.(NUM_BITS-1)
- COEFF_LENGTH, 13, taps per path (≥2)
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- tick_i  in  1  one-cycle strobe: new sample on signal_i
- signal_i  in  NUM_BITS  signed input sample
- ha_coeffs  in  NUM_BITS×COEFF_LENGTH  Hilbert FIR coefficients (drive cos_o)
- delay_coeffs  in  NUM_BITS×COEFF_LENGTH  delay-line FIR coefficients (drive sin_o)
- sin_o  out  NUM_BITS  delayed in-phase result, held between updates
- cos_o  out  NUM_BITS  quadrature result, held between updates
- done_o  out  1  one-cycle pulse: sin_o/cos_o updated this cycle
- busy_o  out  1  high while a computation is in progress (state ≠ IDLE)
- overrun_o  out  1  sticky: a tick arrived while busy

## Operation
- States: IDLE, MAC, FINISH.
- IDLE: on tick_i, write signal_i into ring buffer at wr_ptr; clear both accumulators; tap=0, phase=0; go MAC.
- MAC: one multiply per cycle. Tap k uses sample x[n-k] = buf[(wr_ptr − k) mod COEFF_LENGTH]. phase 0: acc_cos += x·ha_coeffs[k]; phase 1: acc_sin += x·delay_coeffs[k], then tap++. After tap COEFF_LENGTH-1 phase 1 go FINISH.
- FINISH: advance wr_ptr (wrap COEFF_LENGTH-1 → 0); register saturated outputs; pulse done_o; go IDLE.
- Arithmetic: product 2·NUM_BITS bits signed; accumulators 2·NUM_BITS+$clog2(COEFF_LENGTH) bits; result = acc >>> (NUM_BITS-1) (truncation toward −∞), saturated to [−2^(NUM_BITS-1), 2^(NUM_BITS-1)−1].
- Coefficients are read live each MAC cycle; source must hold them stable while busy_o.
- tick_i while busy_o: sample discarded, computation unaffected, overrun_o set until reset.
- Reset (any state): state IDLE, buffer contents 0, wr_ptr 0, accumulators 0, sin_o=cos_o=0, done_o=0, busy_o=0, overrun_o=0. Aborted computation produces no done pulse.

## Timing
- tick_i sampled in cycle 0 → MAC cycles 1..2·COEFF_LENGTH → FINISH cycle 2·COEFF_LENGTH+1 → done_o and new outputs visible in cycle 2·COEFF_LENGTH+2 (28 for default).
- State is IDLE in the done cycle; tick_i in that cycle is accepted. Minimum tick period 2·COEFF_LENGTH+2 cycles.
- busy_o high in cycles 1..2·COEFF_LENGTH+1 after an accepted tick.
- sin_o/cos_o change only in the done_o cycle.

## Structure
- Package hilbert_pkg: state enum typedef, accumulator-width localparam/function, saturation function.
- Sub-module sample_ring_buffer (COEFF_LENGTH×NUM_BITS, write port + one indexed read port, async clear, wr_ptr wrap).
- Scheduler FSM, shared multiplier and two accumulators in the top module.

## Test plan (NUM_BITS=24, COEFF_LENGTH=13)
- Impulse: ha_coeffs[5]=0x400000, delay_coeffs[6]=0x7FFFFF, others 0; signal 0x200000 then zeros, ticks every 30 cycles → cos_o=0x100000 on 6th result only, sin_o=0x1FFFFF on 7th result only, 0 elsewhere.
- Saturation: ha_coeffs[0]=0x800000, signal 0x800000 → cos_o=0x7FFFFF; all ha_coeffs 0x7FFFFF, 13 ticks of 0x7FFFFF → cos_o=0x7FFFFF.
- Latency/back-to-back: tick at cycle 0 → done_o exactly cycle 28; tick at cycle 28 accepted → next done_o cycle 56, overrun_o stays 0.
- Overrun: tick at cycle 0 and cycle 10 → one done_o at 28, results unaffected by second sample, overrun_o=1 from cycle 11 until reset.
- Reset mid-MAC: reset_i at cycle 10 → outputs 0, no done_o; subsequent impulse test matches fresh response (no stale samples).
- Wrap: 40 ticks of random samples/coefficients → every result bit-exact with golden model across wr_ptr wrap.

Source files
------------

// File: rtl/hilbert_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed
// Hilbert transformer scheduler.
package hilbert_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    FINISH
  } state_t;

  // Working width for the saturation helper; must cover the accumulator.
  localparam int SAT_W = 128;

  // Index width for a table of n entries (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Accumulator width: full product plus growth over n taps.
  function automatic int acc_w(input int nb, input int n);
    return 2 * nb + $clog2(n);
  endfunction

  // Rescale a Q2.(2nb-2) sum back to Q1.(nb-1), rounding toward -inf,
  // then clamp to the signed nb-bit range.
  function automatic logic signed [SAT_W-1:0] sat_q(
    input logic signed [SAT_W-1:0] acc,
    input int                      nb
  );
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    s  = acc >>> (nb - 1);
    hi = (128'sd1 <<< (nb - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (nb - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/hilbert_mac_scheduler_sample_ring_buffer.sv
// Sample history for the shared MAC: one write port at wr_ptr and
// one read port addressed by tap distance back from the newest sample.
module sample_ring_buffer
  import hilbert_pkg::*;
#(
  parameter int NUM_BITS = 24,
  parameter int DEPTH    = 13
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [NUM_BITS-1:0]       wr_data,
  input  logic                      advance,
  input  logic [idx_w(DEPTH)-1:0]   rd_tap,
  output logic [NUM_BITS-1:0]       rd_data
);

  localparam int IW = idx_w(DEPTH);

  logic [NUM_BITS-1:0] mem [DEPTH];
  logic [IW-1:0]       wr_ptr;
  logic [IW-1:0]       rd_idx;

  // Storage: cleared on reset so no stale history leaks into a new run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Write pointer moves once per completed computation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (advance) begin
      wr_ptr <= (wr_ptr == IW'(DEPTH - 1)) ? '0 : wr_ptr + IW'(1);
    end
  end

  // x[n-k] lives at (wr_ptr - k) mod DEPTH.
  always_comb begin
    if (wr_ptr >= rd_tap) rd_idx = wr_ptr - rd_tap;
    else                  rd_idx = wr_ptr + IW'(DEPTH) - rd_tap;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/hilbert_mac_scheduler.sv
// Runs the Hilbert (cos) and delay-line (sin) FIR paths through one
// shared multiplier, alternating paths on every tap.
module hilbert_mac_scheduler
  import hilbert_pkg::*;
#(
  parameter int NUM_BITS     = 24,
  parameter int COEFF_LENGTH = 13
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             tick_i,
  input  logic [NUM_BITS-1:0]              signal_i,
  input  logic [NUM_BITS*COEFF_LENGTH-1:0] ha_coeffs,
  input  logic [NUM_BITS*COEFF_LENGTH-1:0] delay_coeffs,
  output logic [NUM_BITS-1:0]              sin_o,
  output logic [NUM_BITS-1:0]              cos_o,
  output logic                             done_o,
  output logic                             busy_o,
  output logic                             overrun_o
);

  localparam int TW = idx_w(COEFF_LENGTH);
  localparam int PW = 2 * NUM_BITS;
  localparam int AW = acc_w(NUM_BITS, COEFF_LENGTH);

  state_t                      state, nstate;
  logic [TW-1:0]               tap;
  logic                        phase;
  logic signed [AW-1:0]        acc_cos, acc_sin;
  logic                        accept, mac_en, fin_en;
  logic [NUM_BITS-1:0]         sample;
  logic signed [NUM_BITS-1:0]  coeff;
  logic signed [PW-1:0]        prod;
  logic signed [NUM_BITS-1:0]  ha_arr [COEFF_LENGTH];
  logic signed [NUM_BITS-1:0]  dl_arr [COEFF_LENGTH];

  for (genvar k = 0; k < COEFF_LENGTH; k++) begin : g_unpack
    assign ha_arr[k] = ha_coeffs[k*NUM_BITS +: NUM_BITS];
    assign dl_arr[k] = delay_coeffs[k*NUM_BITS +: NUM_BITS];
  end

  sample_ring_buffer #(
    .NUM_BITS (NUM_BITS),
    .DEPTH    (COEFF_LENGTH)
  ) u_ring (
    .clk     (clk_i),
    .rst     (reset_i),
    .wr_en   (accept),
    .wr_data (signal_i),
    .advance (fin_en),
    .rd_tap  (tap),
    .rd_data (sample)
  );

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= nstate;
  end

  // Next state: leave MAC after the sin half of the last tap.
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (tick_i) nstate = MAC;
      MAC:     if (phase && tap == TW'(COEFF_LENGTH - 1)) nstate = FINISH;
      FINISH:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // State-decoded controls.
  always_comb begin
    busy_o = (state != IDLE);
    accept = (state == IDLE) && tick_i;
    mac_en = (state == MAC);
    fin_en = (state == FINISH);
  end

  // Shared multiplier: phase 0 feeds cos, phase 1 feeds sin.
  always_comb begin
    coeff = phase ? dl_arr[tap] : ha_arr[tap];
    prod  = PW'($signed(sample)) * PW'(coeff);
  end

  // Tap sequencing and both accumulators.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tap     <= '0;
      phase   <= 1'b0;
      acc_cos <= '0;
      acc_sin <= '0;
    end else if (accept) begin
      tap     <= '0;
      phase   <= 1'b0;
      acc_cos <= '0;
      acc_sin <= '0;
    end else if (mac_en) begin
      phase <= ~phase;
      if (!phase) begin
        acc_cos <= acc_cos + AW'(prod);
      end else begin
        acc_sin <= acc_sin + AW'(prod);
        tap     <= tap + TW'(1);
      end
    end
  end

  // Result registers and the one-cycle done strobe.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cos_o  <= '0;
      sin_o  <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= fin_en;
      if (fin_en) begin
        cos_o <= NUM_BITS'(sat_q(SAT_W'(acc_cos), NUM_BITS));
        sin_o <= NUM_BITS'(sat_q(SAT_W'(acc_sin), NUM_BITS));
      end
    end
  end

  // Sticky flag for samples dropped while a computation runs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)               overrun_o <= 1'b0;
    else if (tick_i && busy_o) overrun_o <= 1'b1;
  end

endmodule

// File: tb/tb_hilbert_mac_scheduler.sv
// Directed + randomized bench for hilbert_mac_scheduler against a
// sample-history FIR model computed with plain integer arithmetic.
module tb_hilbert_mac_scheduler;

  localparam int NB = 24;
  localparam int CL = 13;

  logic             clk_i = 1'b0;
  logic             reset_i = 1'b1;
  logic             tick_i = 1'b0;
  logic [NB-1:0]    signal_i = '0;
  logic [NB*CL-1:0] ha_bus, dl_bus;
  logic [NB-1:0]    sin_o, cos_o;
  logic             done_o, busy_o, overrun_o;

  logic signed [NB-1:0] ha [CL];
  logic signed [NB-1:0] dl [CL];
  longint               hist [$];

  int vectors = 0;
  int miscompares = 0;
  int lat;
  int dcnt;

  hilbert_mac_scheduler #(
    .NUM_BITS     (NB),
    .COEFF_LENGTH (CL)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .tick_i       (tick_i),
    .signal_i     (signal_i),
    .ha_coeffs    (ha_bus),
    .delay_coeffs (dl_bus),
    .sin_o        (sin_o),
    .cos_o        (cos_o),
    .done_o       (done_o),
    .busy_o       (busy_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    ha_bus = '0;
    dl_bus = '0;
    for (int k = 0; k < CL; k++) begin
      ha_bus[k*NB +: NB] = ha[k];
      dl_bus[k*NB +: NB] = dl[k];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // y[n] = sat(floor(sum_k x[n-k]*c[k] / 2^(NB-1)))
  function automatic logic [NB-1:0] ref_out(input bit sin_path);
    longint acc;
    longint x;
    longint c;
    longint hi;
    longint lo;
    acc = 0;
    for (int k = 0; k < CL; k++) begin
      x = (k < hist.size()) ? hist[k] : 0;
      c = sin_path ? longint'(dl[k]) : longint'(ha[k]);
      acc += x * c;
    end
    acc = acc >>> (NB - 1);
    hi  = (longint'(1) << (NB - 1)) - 1;
    lo  = -(longint'(1) << (NB - 1));
    if (acc > hi) acc = hi;
    if (acc < lo) acc = lo;
    return acc[NB-1:0];
  endfunction

  task automatic set_coefs_zero();
    for (int k = 0; k < CL; k++) begin
      ha[k] = '0;
      dl[k] = '0;
    end
  endtask

  task automatic set_coefs_rand();
    for (int k = 0; k < CL; k++) begin
      ha[k] = NB'($urandom);
      dl[k] = NB'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    tick_i  = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;
    hist.delete();
  endtask

  // Tick s now (in the current cycle) or at the next negedge, optionally
  // inject a second tick at cycle extra_at, wait for done and check.
  task automatic run_sample(input logic [NB-1:0] s, input bit now,
                            input int extra_at, output int l);
    logic [NB-1:0] pc;
    if (!now) @(negedge clk_i);
    chk("idle_before_tick", busy_o, 1'b0);
    pc       = cos_o;
    tick_i   = 1'b1;
    signal_i = s;
    hist.push_front(longint'($signed(s)));
    if (hist.size() > CL) void'(hist.pop_back());
    l = 0;
    do begin
      @(negedge clk_i);
      l++;
      tick_i = (extra_at != 0) && (l == extra_at);
      if (tick_i) signal_i = NB'($urandom);
      if (l == 27) chk("cos_held", cos_o, pc);
      if (l == 27) chk("busy_mid", busy_o, 1'b1);
      if (extra_at != 0 && l == extra_at + 1)
        chk("overrun_set", overrun_o, 1'b1);
    end while (!done_o && l < 100);
    tick_i = 1'b0;
    chk("latency", l, 28);
    chk("busy_done", busy_o, 1'b0);
    chk("cos_model", cos_o, ref_out(1'b0));
    chk("sin_model", sin_o, ref_out(1'b1));
  endtask

  initial begin
    set_coefs_zero();
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst_cos", cos_o, '0);
    chk("rst_sin", sin_o, '0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_overrun", overrun_o, 1'b0);

    // Latency and back-to-back ticks in the done cycle.
    set_coefs_rand();
    run_sample(NB'($urandom), 1'b0, 0, lat);
    run_sample(NB'($urandom), 1'b1, 0, lat);
    run_sample(NB'($urandom), 1'b1, 0, lat);
    chk("b2b_no_overrun", overrun_o, 1'b0);

    // Dropped tick mid-computation.
    run_sample(NB'($urandom), 1'b0, 10, lat);
    @(negedge clk_i);
    chk("done_one_cycle", done_o, 1'b0);
    run_sample(NB'($urandom), 1'b0, 0, lat);
    chk("overrun_sticky", overrun_o, 1'b1);
    do_reset();
    chk("overrun_cleared", overrun_o, 1'b0);

    // Abort mid-MAC with history in the buffer.
    set_coefs_rand();
    for (int i = 0; i < 3; i++) run_sample(NB'($urandom), 1'b0, 0, lat);
    @(negedge clk_i);
    tick_i   = 1'b1;
    signal_i = NB'($urandom);
    @(negedge clk_i);
    tick_i = 1'b0;
    repeat (9) @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    chk("abort_cos", cos_o, '0);
    chk("abort_sin", sin_o, '0);
    chk("abort_busy", busy_o, 1'b0);
    @(negedge clk_i);
    reset_i = 1'b0;
    hist.delete();
    dcnt = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);

    // Impulse through the freshly cleared buffer.
    set_coefs_zero();
    ha[5] = 24'h400000;
    dl[6] = 24'h7FFFFF;
    for (int n = 0; n < CL; n++) begin
      run_sample((n == 0) ? 24'h200000 : 24'h0, 1'b0, 0, lat);
      chk("imp_cos", cos_o, (n == 5) ? 24'h100000 : 24'h0);
      chk("imp_sin", sin_o, (n == 6) ? 24'h1FFFFF : 24'h0);
      @(negedge clk_i);
    end

    // Saturation: (-1)*(-1) and a full-scale sum.
    do_reset();
    set_coefs_zero();
    ha[0] = 24'h800000;
    run_sample(24'h800000, 1'b0, 0, lat);
    chk("sat_neg_sq", cos_o, 24'h7FFFFF);
    do_reset();
    for (int k = 0; k < CL; k++) ha[k] = 24'h7FFFFF;
    for (int n = 0; n < CL; n++) run_sample(24'h7FFFFF, 1'b0, 0, lat);
    chk("sat_full", cos_o, 24'h7FFFFF);

    // Random samples and coefficients across several pointer wraps.
    do_reset();
    set_coefs_rand();
    for (int n = 0; n < 40; n++) begin
      run_sample(NB'($urandom), 1'($urandom_range(0, 1)), 0, lat);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk_i);
        chk("wrap_done_pulse", done_o, 1'b0);
      end
    end
    chk("wrap_no_overrun", overrun_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
